// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Owns the scan prescaler, digit sequencing, frame-synchronous capture, hex decode and blanking.
module seg7_scan_driver #(
  parameter int TICK_CYCLES = 131072
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic [15:0] disp_data,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  input  logic        en,
  output logic [3:0]  pos_ctrl,
  output logic [7:0]  num_ctrl,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow_data;
  logic [3:0]       shadow_dp;
  logic             shadow_lz;
  logic             load_pend;

  logic       tick;
  logic       load;
  logic [3:0] nibble;
  logic       blank;
  logic [6:0] seg;

  always_comb begin
    tick   = (cnt == CNT_LAST);
    load   = load_pend || (tick && (idx == 2'd3));
    nibble = shadow_data[{idx, 2'b00} +: 4];

    // A digit is blank only if it and every digit to its left are zero.
    blank = 1'b0;
    case (idx)
      2'd1:    blank = shadow_lz && (shadow_data[15:4]  == 12'h000);
      2'd2:    blank = shadow_lz && (shadow_data[15:8]  == 8'h00);
      2'd3:    blank = shadow_lz && (shadow_data[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase

    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    if (blank) seg = 7'h7F;
  end

  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      idx         <= 2'd0;
      shadow_data <= 16'h0000;
      shadow_dp   <= 4'h0;
      shadow_lz   <= 1'b0;
      load_pend   <= 1'b1;
      pos_ctrl    <= 4'b1111;
      num_ctrl    <= 8'hFF;
      frame_done  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;

      // Shadow copy only moves at frame boundaries so a frame never tears.
      if (load) begin
        shadow_data <= disp_data;
        shadow_dp   <= dp_mask;
        shadow_lz   <= lz_en;
      end
      load_pend  <= 1'b0;
      frame_done <= load;

      pos_ctrl <= en ? ~(4'b0001 << idx) : 4'b1111;
      num_ctrl <= {~shadow_dp[idx], seg};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the stimulus side pushes the expected
// outputs of each upcoming edge, a monitor pops and compares after every edge.
module tb_seg7_scan_driver;

  localparam int TICK  = 4;
  localparam int FRAME = 4 * TICK;

  logic        CLK = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] disp_data = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_en = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  pos_ctrl;
  logic [7:0]  num_ctrl;
  logic        frame_done;

  seg7_scan_driver #(.TICK_CYCLES(TICK)) dut (
    .CLK        (CLK),
    .clr        (clr),
    .disp_data  (disp_data),
    .dp_mask    (dp_mask),
    .lz_en      (lz_en),
    .en         (en),
    .pos_ctrl   (pos_ctrl),
    .num_ctrl   (num_ctrl),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] pos;
    logic [7:0] num;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: edges since reset release and the frame snapshot on display.
  int          n_edge = 0;
  logic [15:0] sh_data = 16'h0000;
  logic [3:0]  sh_dp = 4'h0;
  logic        sh_lz = 1'b0;

  function automatic logic [6:0] glyph(input logic [15:0] d, input logic lz, input int k);
    logic [15:0] upper;
    logic [7:0]  full;
    upper = d >> (4 * k);
    full  = hex_lut[upper[3:0]];
    if (lz && k >= 1 && upper == 16'h0000) return 7'h7F;
    return full[6:0];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Push the expectation for the next rising edge using the current inputs, then wait.
  task automatic step();
    exp_t e;
    int   digit;
    logic [3:0] one_hot;
    if (clr) begin
      e.pos = 4'hF; e.num = 8'hFF; e.fd = 1'b0;
      n_edge = 0; sh_data = 16'h0000; sh_dp = 4'h0; sh_lz = 1'b0;
    end else begin
      n_edge++;
      digit   = ((n_edge - 1) / TICK) % 4;
      one_hot = 4'b0001 << digit;
      e.pos   = en ? ~one_hot : 4'hF;
      e.num   = {~sh_dp[digit], glyph(sh_data, sh_lz, digit)};
      e.fd    = (n_edge == 1) || (n_edge % FRAME == 0);
      if (e.fd) begin
        sh_data = disp_data; sh_dp = dp_mask; sh_lz = lz_en;
      end
    end
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        check("pos_ctrl", {4'h0, pos_ctrl}, {4'h0, e.pos});
        check("num_ctrl", num_ctrl, e.num);
        check("frame_done", {7'h0, frame_done}, {7'h0, e.fd});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int mode;
    run(3);
    clr = 1'b0;
    disp_data = 16'h1234; dp_mask = 4'h0; lz_en = 1'b0; en = 1'b1;
    run(2 * FRAME + 6);
    disp_data = 16'hABCD;
    run(2 * FRAME);

    lz_en = 1'b1; disp_data = 16'h0050;
    run(2 * FRAME);
    disp_data = 16'h0000;
    run(2 * FRAME);
    disp_data = 16'h0050; dp_mask = 4'b1000;
    run(2 * FRAME);
    lz_en = 1'b0; disp_data = 16'h8888; dp_mask = 4'b0100;
    run(2 * FRAME);

    en = 1'b0;
    run(FRAME + 3);
    en = 1'b1;
    run(FRAME);

    // Asynchronous reset between edges must act without a clock.
    #1 clr = 1'b1;
    #1;
    check("async_pos_ctrl", {4'h0, pos_ctrl}, 8'h0F);
    check("async_num_ctrl", num_ctrl, 8'hFF);
    check("async_frame_done", {7'h0, frame_done}, 8'h00);
    step();
    step();
    clr = 1'b0; disp_data = 16'h0907; dp_mask = 4'b0011; lz_en = 1'b1;
    run(2 * FRAME);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0: disp_data = 16'($urandom);
          1: disp_data = 16'($urandom) & 16'h00FF;
          2: disp_data = 16'($urandom) & 16'h000F;
          default: disp_data = 16'h0000;
        endcase
        dp_mask = 4'($urandom);
        lz_en   = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      clr = ($urandom_range(0, 79) == 0);
      step();
    end
    clr = 1'b0;
    run(4);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. Sits directly downstream of the top-level 16-bit display-data select mux.
- Replaces the separate 190 Hz divider plus display-register pair with a single clocked block. Owns the scan prescaler, digit sequencing, frame-synchronous data capture, hex decode, leading-zero blanking and decimal-point control.
- Runs on the board clock, not on the debounced CPU step clock.

Parameters:
- TICK_CYCLES, 131072, board-clock cycles each digit is held; must be ≥2. At 100 MHz this gives about 190 Hz per frame. Use 4 in simulation.
- CNT_W, $clog2(TICK_CYCLES), prescaler counter width. Derived; do not override.

Ports:
- CLK  input  1  board clock; all state changes on its rising edge.
- clr  input  1  reset; asynchronous, active-high.
- disp_data  input  16  value to show. Nibble k drives digit k; digit 0 is rightmost.
- dp_mask  input  4  bit k=1 lights the decimal point of digit k.
- lz_en  input  1  1 = blank leading zero digits.
- en  input  1  0 = all anodes off; scanning continues.
- pos_ctrl  output  4  anode enables, active-low, one-hot; bit k = digit k.
- num_ctrl  output  8  cathodes, active-low; bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
- frame_done  output  1  one-cycle pulse on the edge where the shadow registers reload.

Behaviour:
- Reset (clr=1, async, checked every cycle):
  - cnt=0, idx=0, shadow data/dp/lz=0, load_pend=1.
  - pos_ctrl=4'b1111, num_ctrl=8'hFF, frame_done=0.
- Prescaler:
  - cnt counts 0..TICK_CYCLES-1 and wraps to 0.
  - tick = (cnt==TICK_CYCLES-1).
  - On tick, idx increments mod 4 (3→0 wraps).
- Shadow load (frame-synchronous, anti-tearing):
  - disp_data, dp_mask and lz_en are captured into shadow registers on the first edge after clr deasserts (load_pend=1, which then clears).
  - They are also captured on every edge where tick && idx==3.
  - Input changes at any other time have no visible effect.
  - frame_done=1 on exactly the edges where a shadow load occurs, else 0.
- Output stage (registered; one cycle after the idx/shadow value it reflects):
  - pos_ctrl = en ? ~(4'b0001<<idx) : 4'b1111.
  - num_ctrl[6:0] = hex decode of shadow nibble idx.
  - num_ctrl[7] = ~shadow_dp[idx].
- Hex decode (full byte with dp off):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Leading-zero blanking:
  - Digit k (k≥1) is blanked when shadow_lz=1 and shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives num_ctrl[6:0]=7'h7F; its dp still follows dp_mask; its anode still cycles.
- en=0: anodes off, num_ctrl still decoded; cnt, idx and shadow loads continue unaffected.
- Reset mid-frame: outputs go to their reset values immediately (async). Scanning restarts at digit 0 with a fresh shadow load on the first edge after release.

Test Plan (TICK_CYCLES=4):
- Reset check: assert clr mid-run → pos_ctrl=1111, num_ctrl=FF, frame_done=0 with no clock edge required. Release → frame_done pulses on the first edge.
- Scan order: disp_data=16'h1234, lz_en=0, dp_mask=0, en=1 → repeating sequence (1110,99), (1101,B0), (1011,A4), (0111,F9). Each pair is held 4 cycles. frame_done pulses every 16 cycles.
- Anti-tearing: switch disp_data from 16'h1234 to 16'hABCD while digit 1 is showing → remaining digits of that frame still show 2 and 1. The next frame shows 88 on digit 3, 83 on digit 2, C6 on digit 1, A1 on digit 0.
- Leading-zero blanking, lz_en=1:
  - disp_data=16'h0050 → digits 3 and 2 = FF, digit 1 = 92, digit 0 = C0.
  - disp_data=16'h0000 → digits 3..1 = FF, digit 0 = C0.
  - disp_data=16'h0050 with dp_mask=4'b1000 → digit 3 num_ctrl=7F.
- Decimal point: disp_data=16'h8888, dp_mask=4'b0100 → digit 2 num_ctrl=00, all other digits 80.
- Enable gating: en=0 for one full frame → pos_ctrl=1111 throughout, frame_done still pulses every 16 cycles. Restore en=1 → scanning continues at the current idx with no restart.
